// File: rtl/div_unit_if.sv
// Handshake and data bundle between the execute stage and the divider.
// The master drives the operands and the request; the slave returns the result.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU.
// Produces one quotient bit per cycle on operand magnitudes, then fixes up the signs.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               sgn_a;
  logic               sgn_b;
  logic               sgn_mode;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     sub;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mag_a = bus.opdata1_i;
    mag_b = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) mag_a = -bus.opdata1_i;
    if (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) mag_b = -bus.opdata2_i;
    rem_sh = {rem, quo[WIDTH-1]};
    // rem_sh < 2*dvs, so bit WIDTH of the (WIDTH+1)-bit difference is the borrow.
    sub    = rem_sh - {1'b0, dvs};
  end

  // NOTE: sequential state is assigned with <= only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      sgn_mode <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      unique case (state)
        FREE: begin
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state    <= ON;
              rem      <= '0;
              quo      <= mag_a;
              dvs      <= mag_b;
              sgn_a    <= bus.opdata1_i[WIDTH-1];
              sgn_b    <= bus.opdata2_i[WIDTH-1];
              sgn_mode <= bus.signed_div_i;
              cnt      <= '0;
            end
          end
        end
        BYZERO: begin
          if (bus.annul_i) begin
            state <= FREE;
          end else begin
            state  <= END;
            result <= '0;
            ready  <= 1'b1;
          end
        end
        ON: begin
          if (bus.annul_i) begin
            state  <= FREE;
            cnt    <= '0;
            result <= '0;
            ready  <= 1'b0;
          end else if (cnt == CNT_W'(WIDTH)) begin
            state <= END;
            result[WIDTH-1:0]       <= (sgn_mode && (sgn_a != sgn_b)) ? -quo : quo;
            result[2*WIDTH-1:WIDTH] <= (sgn_mode && sgn_a) ? -rem : rem;
            ready <= 1'b1;
          end else begin
            if (!sub[WIDTH]) begin
              rem <= sub[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= rem_sh[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        END: begin
          if (bus.annul_i || !bus.start_i) begin
            state  <= FREE;
            result <= '0;
            ready  <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = (state == ON) || (state == BYZERO);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero,
// annul, asynchronous reset and operand isolation after acceptance.
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic          sd;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [63:0]   exp;
  } vec_t;

  task automatic start_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
  endtask

  // Counts edges after the accepting edge until ready is seen; returns at a negedge.
  task automatic wait_ready(output int edges, output bit timeout);
    edges   = 0;
    timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic end_div;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #12;
    checks++;
    if (bus.result_o !== 64'h0) begin
      errors++; $display("FAIL reset_result got %h want %h", bus.result_o, 64'h0);
    end
    checks++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags got ready=%b busy=%b want 0 0", bus.ready_o, bus.busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu_latency;
    int edges; bit to;
    start_div(1'b0, 32'd7, 32'd2);
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL divu_busy got %b want 1", bus.busy_o);
    end
    wait_ready(edges, to);
    edges++;
    checks++;
    if (to || edges != 33) begin
      errors++; $display("FAIL divu_latency got %0d edges (timeout=%0d) want 33", edges, to);
    end
    checks++;
    if (bus.result_o !== {32'h1, 32'h3}) begin
      errors++; $display("FAIL divu_7_2 got %h want %h", bus.result_o, {32'h1, 32'h3});
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL divu_busy_end got %b want 0", bus.busy_o);
    end
    end_div();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      errors++; $display("FAIL divu_release got ready=%b result=%h want 0 0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_signed_table;
    vec_t vecs[6];
    int edges; bit to;
    vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[1] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}};
    vecs[5] = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, {32'h0000_0001, 32'h7FFF_FFFC}};
    for (int i = 0; i < 6; i++) begin
      start_div(vecs[i].sd, vecs[i].a, vecs[i].b);
      wait_ready(edges, to);
      checks++;
      if (to || bus.result_o !== vecs[i].exp) begin
        errors++;
        $display("FAIL div_vec%0d got %h (timeout=%0d) want %h", i, bus.result_o, to, vecs[i].exp);
      end
      end_div();
    end
  endtask

  task automatic test_div_by_zero;
    int edges; bit to;
    start_div(1'b1, 32'h0000_1234, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin
      errors++; $display("FAIL dbz_e0 got busy=%b ready=%b want 1 0", bus.busy_o, bus.ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL dbz_e1 got ready=%b result=%h busy=%b want 1 0 0",
                         bus.ready_o, bus.result_o, bus.busy_o);
    end
    end_div();
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++; $display("FAIL dbz_release got ready=%b want 0", bus.ready_o);
    end
    // Back-to-back: start again in the very next cycle after returning to FREE.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd7;
    bus.opdata2_i    = 32'd2;
    bus.start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy_o);
    end
    wait_ready(edges, to);
    checks++;
    if (to || bus.result_o !== {32'h1, 32'h3}) begin
      errors++; $display("FAIL b2b_result got %h (timeout=%0d) want %h", bus.result_o, to, {32'h1, 32'h3});
    end
    end_div();
  endtask

  task automatic test_annul;
    int edges; bit to; bit seen;
    start_div(1'b0, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      errors++; $display("FAIL annul_state got busy=%b ready=%b want 0 0", bus.busy_o, bus.ready_o);
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_o) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL annul_no_ready got ready seen=1 want 0");
    end
    start_div(1'b0, 32'd100, 32'd3);
    wait_ready(edges, to);
    checks++;
    if (to || bus.result_o !== {32'h1, 32'h21}) begin
      errors++; $display("FAIL annul_retry got %h (timeout=%0d) want %h", bus.result_o, to, {32'h1, 32'h21});
    end
    end_div();
  endtask

  task automatic test_operand_change;
    int edges; bit to;
    start_div(1'b0, 32'd100, 32'd3);
    @(negedge clk);
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFF_FFF5;
    bus.opdata2_i    = 32'd7;
    wait_ready(edges, to);
    checks++;
    if (to || bus.result_o !== {32'h1, 32'h21}) begin
      errors++; $display("FAIL latch_operands got %h (timeout=%0d) want %h", bus.result_o, to, {32'h1, 32'h21});
    end
    end_div();
  endtask

  task automatic test_async_reset;
    int edges; bit to;
    start_div(1'b0, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      errors++; $display("FAIL arst_on got busy=%b ready=%b want 0 0", bus.busy_o, bus.ready_o);
    end
    bus.start_i = 1'b0;
    #1 rst = 1'b0;
    start_div(1'b0, 32'd7, 32'd2);
    wait_ready(edges, to);
    checks++;
    if (to || bus.result_o !== {32'h1, 32'h3}) begin
      errors++; $display("FAIL arst_prep got %h (timeout=%0d) want %h", bus.result_o, to, {32'h1, 32'h3});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      errors++; $display("FAIL arst_end got ready=%b result=%h want 0 0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_divu_latency();
    test_signed_table();
    test_div_by_zero();
    test_annul();
    test_operand_change();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
